memory_bus_responder: RTL and testbench
=======================================

Name: memory_bus_responder

Overview:
- Memory-side responder for the CPU's single-port memory bus (memory_address, memory_write_data, memory_write_enable in; memory_read_data out).
- Decodes each bus access to one of three targets: word RAM, a small memory-mapped I/O page, or unmapped space.
- Returns read data with fixed 1-cycle latency, which matches the CPU's fetch/load timing.
- Sits at top level between the cpu instance and board I/O (switches, LEDs).

Parameters:
- WIDTH, 16, bus data and address width.
- RAM_ADDRESS_BITS, 10, log2 of RAM depth in words; RAM occupies 0 .. 2^RAM_ADDRESS_BITS-1.
- IO_BASE, 16'hFF00, base of the 4-word I/O page.
- SWITCH_BITS, 10, width of the switch input and LED output.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- memory_address  in  WIDTH  word address from the CPU.
- memory_write_data  in  WIDTH  write data from the CPU.
- memory_write_enable  in  1  write strobe, one access per cycle.
- memory_read_data  out  WIDTH  registered read data for the address presented on the previous cycle.
- switches  in  SWITCH_BITS  asynchronous board switches.
- leds  out  SWITCH_BITS  LED register output.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clock and reset.
- Reset: memory_read_data=0, leds=0, timer=0, overflow flag=0, switch synchronizer flops=0. RAM contents are not cleared.
- While reset is high, all writes are ignored, including RAM writes.
- Decode, evaluated on the current address:
  - RAM when address < 2^RAM_ADDRESS_BITS.
  - IO when address[WIDTH-1:2] == IO_BASE[WIDTH-1:2].
  - Otherwise unmapped.
- Read latency is exactly 1 cycle. memory_read_data updates every cycle, whether or not memory_write_enable is high.
- Read-during-write at the same address returns the OLD value (read-first), for both RAM and IO registers.
- IO map, as offset from IO_BASE:
  - +0 LED: read/write. A write loads memory_write_data[SWITCH_BITS-1:0]. Reads are zero-extended.
  - +1 SWITCH: read-only. Value is switches passed through a 2-flop synchronizer, so it lags the pin by 2 cycles. Writes are ignored.
  - +2 TIMER: free-running 16-bit cycle counter, increments every non-reset cycle and wraps FFFF->0000. A write loads the value; write has priority over increment in that cycle, and the counter increments from the written value on the next cycle.
  - +3 STATUS: bit0 = sticky overflow flag, set on the cycle TIMER wraps FFFF->0000. Writing 1 to bit0 clears it; writing 0 has no effect. Set has priority over clear in the same cycle. Bits 15:1 read 0.
- Unmapped: reads return 0, writes are ignored with no side effects.
- Writes to RAM and IO take effect at the clock edge of the access cycle.
- The internal registered address select drives the output mux, so the response always corresponds to the previous cycle's decode.

Test Plan:
- Reset asserted 3 cycles, then released -> memory_read_data=0000, leds=000, STATUS reads 0000. TIMER read at the first post-reset address cycle returns 0000.
- Write RAM[0x0005]=ABCD, then address 0x0005 with no write -> read_data=ABCD one cycle later. Write 1234 to 0x0005 while reading it -> that response is ABCD, and the next read returns 1234.
- Write 0x03FF to FF00 -> leds=3FF the following cycle. Read FF00 -> 03FF. Set switches=0x2A5 -> FF01 reads 02A5 no earlier than 2 cycles after the change.
- Write FFFE to FF02, then idle 2 cycles -> TIMER wraps and FF03 reads 0001. Write 0001 to FF03 -> reads 0000. Write FFFF to FF02 and clear STATUS on the wrap cycle -> STATUS stays 0001 (set wins).
- Write 5555 to 0x8000 (unmapped) -> read 0x8000 returns 0000. RAM[0x0000] and the IO registers are unchanged.
- Assert reset in the same cycle as a RAM write to 0x0010 of BEEF -> RAM[0x0010] keeps its prior value and read_data=0000 on the cycle after reset.

Source files
------------

// File: rtl/memory_bus_responder.sv
// memory_bus_responder: single-port bus target decoding word RAM, a 4-word I/O page and unmapped space
// Ports: clock/reset (sync, active-high); memory_address, memory_write_data, memory_write_enable in;
//        memory_read_data out (1-cycle latency, read-first); switches in (async); leds out.
module memory_bus_responder #(
  parameter int WIDTH = 16,
  parameter int RAM_ADDRESS_BITS = 10,
  parameter logic [WIDTH-1:0] IO_BASE = 16'hFF00,
  parameter int SWITCH_BITS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic [WIDTH-1:0] memory_address,
  input  logic [WIDTH-1:0] memory_write_data,
  input  logic memory_write_enable,
  output logic [WIDTH-1:0] memory_read_data,
  input  logic [SWITCH_BITS-1:0] switches,
  output logic [SWITCH_BITS-1:0] leds
);
  typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_IO} sel_t;
  logic [WIDTH-1:0] mem [0:(1<<RAM_ADDRESS_BITS)-1];
  logic [RAM_ADDRESS_BITS-1:0] ram_index;
  logic [WIDTH-1:0] ram_rd_q;
  logic is_ram, is_io, io_we, timer_we;
  logic [1:0] offset;
  sel_t sel_d, sel_q;
  logic [SWITCH_BITS-1:0] led_d, led_q, sw_meta_q, sw_sync_q;
  logic [WIDTH-1:0] timer_d, timer_q, io_rd_d, io_rd_q;
  logic ovf_d, ovf_q;
  always_comb begin
    ram_index = memory_address[RAM_ADDRESS_BITS-1:0];
    offset = memory_address[1:0];
    is_ram = memory_address[WIDTH-1:RAM_ADDRESS_BITS] == '0;
    is_io = memory_address[WIDTH-1:2] == IO_BASE[WIDTH-1:2];
    io_we = memory_write_enable && is_io;
    timer_we = io_we && offset == 2'd2;
    sel_d = is_ram ? SEL_RAM : is_io ? SEL_IO : SEL_NONE;
    led_d = (io_we && offset == 2'd0) ? memory_write_data[SWITCH_BITS-1:0] : led_q;
    timer_d = timer_we ? memory_write_data : timer_q + WIDTH'(1);
    // a wrap only happens when the counter actually increments out of all-ones; set beats clear
    ovf_d = (!timer_we && timer_q == '1) ? 1'b1 :
            (io_we && offset == 2'd3 && memory_write_data[0]) ? 1'b0 : ovf_q;
    // sampled from current register values, so a same-cycle write returns the old contents
    io_rd_d = offset == 2'd0 ? WIDTH'(led_q) :
              offset == 2'd1 ? WIDTH'(sw_sync_q) :
              offset == 2'd2 ? timer_q : WIDTH'(ovf_q);
    memory_read_data = sel_q == SEL_RAM ? ram_rd_q : sel_q == SEL_IO ? io_rd_q : '0;
    leds = led_q;
  end
  always_ff @(posedge clock) begin
    if (!reset && memory_write_enable && is_ram) mem[ram_index] <= memory_write_data;
    ram_rd_q <= mem[ram_index];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q <= SEL_NONE;
      led_q <= '0;
      timer_q <= '0;
      ovf_q <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      io_rd_q <= '0;
    end else begin
      sel_q <= sel_d;
      led_q <= led_d;
      timer_q <= timer_d;
      ovf_q <= ovf_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      io_rd_q <= io_rd_d;
    end
  end
endmodule

// File: tb/tb_memory_bus_responder.sv
// tb_memory_bus_responder: directed self-checking bench for memory_bus_responder
module tb_memory_bus_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] memory_address = 16'h0000;
  logic [15:0] memory_write_data = 16'h0000;
  logic memory_write_enable = 1'b0;
  logic [15:0] memory_read_data;
  logic [9:0] switches = 10'h000;
  logic [9:0] leds;
  int total = 0;
  int bad = 0;

  memory_bus_responder dut (
    .clock(clock),
    .reset(reset),
    .memory_address(memory_address),
    .memory_write_data(memory_write_data),
    .memory_write_enable(memory_write_enable),
    .memory_read_data(memory_read_data),
    .switches(switches),
    .leds(leds)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic we, input logic [15:0] wd);
    memory_address = a;
    memory_write_enable = we;
    memory_write_data = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(16'hFF02, 1'b0, 16'h0000);
    repeat (3) step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL reset_rd got=%h exp=0000", memory_read_data); end
    total++; if (leds !== 10'h000) begin bad++; $display("FAIL reset_leds got=%h exp=000", leds); end
    reset = 1'b0;
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL reset_timer got=%h exp=0000", memory_read_data); end
    drive(16'hFF03, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL reset_status got=%h exp=0000", memory_read_data); end
  endtask

  task automatic test_ram();
    drive(16'h0005, 1'b1, 16'hABCD);
    step();
    drive(16'h0005, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'hABCD) begin bad++; $display("FAIL ram_read got=%h exp=abcd", memory_read_data); end
    drive(16'h0005, 1'b1, 16'h1234);
    step();
    total++; if (memory_read_data !== 16'hABCD) begin bad++; $display("FAIL ram_read_first got=%h exp=abcd", memory_read_data); end
    drive(16'h0005, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h1234) begin bad++; $display("FAIL ram_new got=%h exp=1234", memory_read_data); end
    drive(16'h03FF, 1'b1, 16'h7E57);
    step();
    drive(16'h03FF, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h7E57) begin bad++; $display("FAIL ram_top got=%h exp=7e57", memory_read_data); end
  endtask

  task automatic test_led_switch();
    drive(16'hFF00, 1'b1, 16'h03FF);
    step();
    total++; if (leds !== 10'h3FF) begin bad++; $display("FAIL led_out got=%h exp=3ff", leds); end
    drive(16'hFF00, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h03FF) begin bad++; $display("FAIL led_read got=%h exp=03ff", memory_read_data); end
    drive(16'hFF00, 1'b1, 16'hF15A);
    step();
    total++; if (memory_read_data !== 16'h03FF) begin bad++; $display("FAIL led_read_first got=%h exp=03ff", memory_read_data); end
    drive(16'hFF00, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h015A) begin bad++; $display("FAIL led_trunc got=%h exp=015a", memory_read_data); end
    total++; if (leds !== 10'h15A) begin bad++; $display("FAIL led_out2 got=%h exp=15a", leds); end
    drive(16'hFF00, 1'b1, 16'h03FF);
    step();
    switches = 10'h2A5;
    drive(16'hFF01, 1'b1, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL sw_lag1 got=%h exp=0000", memory_read_data); end
    drive(16'hFF01, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL sw_lag2 got=%h exp=0000", memory_read_data); end
    step();
    total++; if (memory_read_data !== 16'h02A5) begin bad++; $display("FAIL sw_read got=%h exp=02a5", memory_read_data); end
  endtask

  task automatic test_timer_status();
    drive(16'hFF02, 1'b1, 16'hFFFE);
    step();
    drive(16'h0000, 1'b0, 16'h0000);
    step();
    step();
    drive(16'hFF02, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL timer_wrap got=%h exp=0000", memory_read_data); end
    drive(16'hFF03, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0001) begin bad++; $display("FAIL ovf_set got=%h exp=0001", memory_read_data); end
    drive(16'hFF03, 1'b1, 16'hFFFE);
    step();
    drive(16'hFF03, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0001) begin bad++; $display("FAIL ovf_write0 got=%h exp=0001", memory_read_data); end
    drive(16'hFF03, 1'b1, 16'h0001);
    step();
    total++; if (memory_read_data !== 16'h0001) begin bad++; $display("FAIL ovf_clr_rf got=%h exp=0001", memory_read_data); end
    drive(16'hFF03, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL ovf_clr got=%h exp=0000", memory_read_data); end
    drive(16'hFF02, 1'b1, 16'h0100);
    step();
    drive(16'hFF02, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0100) begin bad++; $display("FAIL timer_load got=%h exp=0100", memory_read_data); end
    step();
    total++; if (memory_read_data !== 16'h0101) begin bad++; $display("FAIL timer_inc got=%h exp=0101", memory_read_data); end
    drive(16'hFF02, 1'b1, 16'hFFFF);
    step();
    drive(16'hFF03, 1'b1, 16'h0001);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL ovf_pre got=%h exp=0000", memory_read_data); end
    drive(16'hFF03, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0001) begin bad++; $display("FAIL ovf_set_wins got=%h exp=0001", memory_read_data); end
    drive(16'hFF03, 1'b1, 16'h0001);
    step();
    drive(16'hFF03, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL ovf_clr2 got=%h exp=0000", memory_read_data); end
  endtask

  task automatic test_unmapped();
    drive(16'h0000, 1'b1, 16'h1111);
    step();
    drive(16'h8000, 1'b1, 16'h5555);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL unmap_rw got=%h exp=0000", memory_read_data); end
    drive(16'h8000, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL unmap_rd got=%h exp=0000", memory_read_data); end
    drive(16'h0400, 1'b1, 16'h5555);
    step();
    drive(16'hFF04, 1'b1, 16'h5555);
    step();
    drive(16'h0400, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL unmap_0400 got=%h exp=0000", memory_read_data); end
    drive(16'h0000, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h1111) begin bad++; $display("FAIL unmap_ram0 got=%h exp=1111", memory_read_data); end
    drive(16'hFF00, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h03FF) begin bad++; $display("FAIL unmap_led got=%h exp=03ff", memory_read_data); end
    drive(16'hFF03, 1'b0, 16'h0000);
    step();
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL unmap_status got=%h exp=0000", memory_read_data); end
  endtask

  task automatic test_reset_write();
    drive(16'h0010, 1'b1, 16'hCAFE);
    step();
    reset = 1'b1;
    drive(16'h0010, 1'b1, 16'hBEEF);
    step();
    reset = 1'b0;
    drive(16'h0010, 1'b0, 16'h0000);
    total++; if (memory_read_data !== 16'h0000) begin bad++; $display("FAIL rstw_rd got=%h exp=0000", memory_read_data); end
    total++; if (leds !== 10'h000) begin bad++; $display("FAIL rstw_leds got=%h exp=000", leds); end
    step();
    total++; if (memory_read_data !== 16'hCAFE) begin bad++; $display("FAIL rstw_ram got=%h exp=cafe", memory_read_data); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_switch();
    test_timer_status();
    test_unmapped();
    test_reset_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
